// File: rtl/div_ctrl.sv
// div_ctrl: 32-step restoring divider control for DIV/DIVU/REM/REMU.
// Define DIV_ZERO_FAST_EN to retire divide-by-zero and signed overflow in one cycle.
module div_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic [4:0]      rd_addr_i,
  output logic            busy_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o,
  output logic [4:0]      rd_addr_o,
  output logic            stallreq_o
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state_q, state_d;
  logic [5:0]      cnt_q;
  logic [1:0]      op_q;
  logic [4:0]      rd_q;
  logic            neg_a_q, neg_b_q, dz_q;
  logic [XLEN-1:0] dvs_q, rem_q, quo_q;

  logic            is_signed, a_neg, b_neg, dz, fast, accept;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN:0]   shl, diff;
  logic [XLEN-1:0] q_res, r_res, res;

  always_comb begin
    is_signed = ~op_i[0];
    a_neg     = is_signed & dividend_i[XLEN-1];
    b_neg     = is_signed & divisor_i[XLEN-1];
    a_mag     = a_neg ? -dividend_i : dividend_i;
    b_mag     = b_neg ? -divisor_i : divisor_i;
    dz        = (divisor_i == '0);
`ifdef DIV_ZERO_FAST_EN
    fast      = dz | (is_signed & (dividend_i == MIN)
                      & (divisor_i == '1));
`else
    fast      = 1'b0;
`endif
    accept    = (state_q == IDLE) & start_i & ~flush_i;
  end

  always_comb begin
    shl  = {rem_q, quo_q[XLEN-1]};
    diff = shl - {1'b0, dvs_q};
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = fast ? DONE : CALC;
      CALC: if (cnt_q == 6'd31) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      op_q    <= '0;
      rd_q    <= '0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      dz_q    <= 1'b0;
      dvs_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
    end else if (accept) begin
      cnt_q   <= '0;
      op_q    <= op_i;
      rd_q    <= rd_addr_i;
      neg_a_q <= a_neg;
      neg_b_q <= b_neg;
      dz_q    <= dz;
      dvs_q   <= b_mag;
      rem_q   <= '0;
      quo_q   <= a_mag;
`ifdef DIV_ZERO_FAST_EN
      // fast x/0 skips CALC: preload the remainder the steps would produce
      if (dz) rem_q <= a_mag;
`endif
    end else if (state_q == CALC) begin
      cnt_q <= cnt_q + 6'd1;
      if (!diff[XLEN]) begin
        rem_q <= diff[XLEN-1:0];
        quo_q <= {quo_q[XLEN-2:0], 1'b1};
      end else begin
        rem_q <= shl[XLEN-1:0];
        quo_q <= {quo_q[XLEN-2:0], 1'b0};
      end
    end
  end

  always_comb begin
    q_res = dz_q ? '1
          : ((neg_a_q ^ neg_b_q) ? -quo_q : quo_q);
    r_res = neg_a_q ? -rem_q : rem_q;
    res   = op_q[1] ? r_res : q_res;
  end

  assign busy_o     = (state_q != IDLE);
  assign valid_o    = (state_q == DONE);
  assign result_o   = valid_o ? res : '0;
  assign rd_addr_o  = rd_q;
  assign stallreq_o = ~rst & (accept | (state_q == CALC));

endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: randomized and directed checks of div_ctrl
// against an arithmetic reference model.
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        flush_i;
  logic [1:0]  op_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic [4:0]  rd_addr_i;
  logic        busy_o;
  logic        valid_o;
  logic [31:0] result_o;
  logic [4:0]  rd_addr_o;
  logic        stallreq_o;

  int n_chk  = 0;
  int n_fail = 0;

  localparam logic [31:0] MIN = 32'h8000_0000;

  div_ctrl #(.XLEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .flush_i    (flush_i),
    .op_i       (op_i),
    .dividend_i (dividend_i),
    .divisor_i  (divisor_i),
    .rd_addr_i  (rd_addr_i),
    .busy_o     (busy_o),
    .valid_o    (valid_o),
    .result_o   (result_o),
    .rd_addr_o  (rd_addr_o),
    .stallreq_o (stallreq_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_div(input logic [1:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    int sa, sb;
    sa = int'(a);
    sb = int'(b);
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == MIN && b == 32'hFFFF_FFFF)
      return op[1] ? 32'd0 : MIN;
    case (op)
      2'b00:   return 32'(sa / sb);
      2'b01:   return a / b;
      2'b10:   return 32'(sa % sb);
      default: return a % b;
    endcase
  endfunction

  function automatic bit fast_case(input logic [1:0] op,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
`ifdef DIV_ZERO_FAST_EN
    return (b == 32'd0) || (!op[0] && a == MIN && b == 32'hFFFF_FFFF);
`else
    return 1'b0;
`endif
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input string name, input logic [1:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    logic [31:0] exp_r;
    int lat;
    exp_r = ref_div(op, a, b);
    lat = fast_case(op, a, b) ? 1 : 33;
    op_i = op; dividend_i = a; divisor_i = b; rd_addr_i = rd;
    start_i = 1'b1;
    @(negedge clk);
    n_chk++;
    if (stallreq_o !== 1'b1) begin
      n_fail++;
      $display("FAIL %s stall_T: got %b want 1", name, stallreq_o);
    end
    tick;
    for (int k = 1; k <= lat + 1; k++) begin
      start_i    = (k <= lat);
      op_i       = 2'($urandom);
      dividend_i = $urandom;
      divisor_i  = $urandom;
      rd_addr_i  = 5'($urandom);
      @(negedge clk);
      n_chk++;
      if (valid_o !== 1'(k == lat)) begin
        n_fail++;
        $display("FAIL %s valid@T+%0d: got %b want %b",
                 name, k, valid_o, (k == lat));
      end
      n_chk++;
      if (stallreq_o !== 1'(k < lat)) begin
        n_fail++;
        $display("FAIL %s stall@T+%0d: got %b want %b",
                 name, k, stallreq_o, (k < lat));
      end
      n_chk++;
      if (busy_o !== 1'(k <= lat)) begin
        n_fail++;
        $display("FAIL %s busy@T+%0d: got %b want %b",
                 name, k, busy_o, (k <= lat));
      end
      if (k == lat) begin
        n_chk++;
        if (result_o !== exp_r) begin
          n_fail++;
          $display("FAIL %s result op=%0d a=%h b=%h: got %h want %h",
                   name, op, a, b, result_o, exp_r);
        end
        n_chk++;
        if (rd_addr_o !== rd) begin
          n_fail++;
          $display("FAIL %s rd: got %0d want %0d", name, rd_addr_o, rd);
        end
      end else begin
        n_chk++;
        if (result_o !== 32'd0) begin
          n_fail++;
          $display("FAIL %s result_idle@T+%0d: got %h want 0",
                   name, k, result_o);
        end
      end
      tick;
    end
    start_i = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start_i = 1'b0; flush_i = 1'b0;
    op_i = 2'($urandom); dividend_i = $urandom;
    divisor_i = $urandom; rd_addr_i = 5'($urandom);
    tick;
    tick;
    @(negedge clk);
    n_chk++;
    if ({busy_o, valid_o, stallreq_o} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 000",
               {busy_o, valid_o, stallreq_o});
    end
    n_chk++;
    if (result_o !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_result: got %h want 0", result_o);
    end
    n_chk++;
    if (rd_addr_o !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_rd: got %0d want 0", rd_addr_o);
    end
    rst = 1'b0;
    tick;
  endtask

  task automatic test_directed;
    do_op("divu_100_7", 2'b01, 32'd100, 32'd7, 5'd5);
    do_op("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 5'd1);
    do_op("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 5'd2);
    do_op("div_5_0", 2'b00, 32'd5, 32'd0, 5'd3);
    do_op("remu_5_0", 2'b11, 32'd5, 32'd0, 5'd4);
    do_op("div_neg_0", 2'b00, 32'hFFFF_FF00, 32'd0, 5'd6);
    do_op("rem_neg_0", 2'b10, 32'hFFFF_FF00, 32'd0, 5'd7);
    do_op("div_ovf", 2'b00, MIN, 32'hFFFF_FFFF, 5'd8);
    do_op("rem_ovf", 2'b10, MIN, 32'hFFFF_FFFF, 5'd9);
    do_op("divu_max_1", 2'b01, 32'hFFFF_FFFF, 32'd1, 5'd31);
  endtask

  task automatic test_random;
    logic [31:0] a, b;
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = MIN; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: a = 32'($urandom_range(0, 1000));
        4: b = 32'd0 - 32'($urandom_range(1, 9));
        default: ;
      endcase
      do_op("random", 2'($urandom), a, b, 5'($urandom));
    end
  endtask

  task automatic test_flush;
    op_i = 2'b01; dividend_i = 32'd100; divisor_i = 32'd7;
    rd_addr_i = 5'd3; start_i = 1'b1; flush_i = 1'b0;
    tick;
    for (int k = 1; k <= 46; k++) begin
      flush_i = (k == 10);
      start_i = (k == 12);
      if (k == 12) begin
        op_i = 2'b01; dividend_i = 32'd1000;
        divisor_i = 32'd10; rd_addr_i = 5'd9;
      end
      @(negedge clk);
      n_chk++;
      if (valid_o !== 1'(k == 45)) begin
        n_fail++;
        $display("FAIL flush_valid@T+%0d: got %b want %b",
                 k, valid_o, (k == 45));
      end
      if (k == 11) begin
        n_chk++;
        if (busy_o !== 1'b0) begin
          n_fail++;
          $display("FAIL flush_busy: got %b want 0", busy_o);
        end
      end
      if (k == 12) begin
        n_chk++;
        if (stallreq_o !== 1'b1) begin
          n_fail++;
          $display("FAIL flush_restart_stall: got %b want 1", stallreq_o);
        end
      end
      if (k == 45) begin
        n_chk++;
        if (result_o !== 32'd100 || rd_addr_o !== 5'd9) begin
          n_fail++;
          $display("FAIL flush_second_result: got %h/%0d want 64/9",
                   result_o, rd_addr_o);
        end
      end
      tick;
    end
    start_i = 1'b0;
    flush_i = 1'b0;
  endtask

  task automatic test_reset_mid;
    bit seen;
    op_i = 2'b00; dividend_i = $urandom; divisor_i = 32'd3;
    rd_addr_i = 5'd12; start_i = 1'b1;
    tick;
    start_i = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      rst = (k == 20);
      if (k < 20) tick;
    end
    tick;
    rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({busy_o, valid_o, stallreq_o} !== 3'b000 ||
        result_o !== 32'd0 || rd_addr_o !== 5'd0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: got b%b v%b s%b r%h rd%0d want all 0",
               busy_o, valid_o, stallreq_o, result_o, rd_addr_o);
    end
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick;
      @(negedge clk);
      if (valid_o || busy_o) seen = 1'b1;
    end
    n_chk++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_no_valid: got activity 1 want 0");
    end
    tick;
    start_i = 1'b1; flush_i = 1'b1;
    op_i = 2'b01; dividend_i = 32'd50; divisor_i = 32'd5;
    @(negedge clk);
    n_chk++;
    if (stallreq_o !== 1'b0) begin
      n_fail++;
      $display("FAIL start_flush_stall: got %b want 0", stallreq_o);
    end
    tick;
    start_i = 1'b0; flush_i = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (valid_o || busy_o) seen = 1'b1;
      tick;
    end
    n_chk++;
    if (seen !== 1'b0) begin
      n_fail++;
      $display("FAIL start_flush_ignored: got activity 1 want 0");
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_flush;
    test_reset_mid;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand and result width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  single clock, all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start_i  input  1  request a divide; sampled only in IDLE.
REQ-005 SHALL have port flush_i  input  1  abort the current operation (pipeline flush).
REQ-006 SHALL have port op_i  input  2  operation select: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-007 SHALL have port dividend_i  input  32  rs1 value.
REQ-008 SHALL have port divisor_i  input  32  rs2 value.
REQ-009 SHALL have port rd_addr_i  input  5  destination register of the request.
REQ-010 SHALL have port busy_o  output  1  high in CALC and DONE.
REQ-011 SHALL have port valid_o  output  1  one-cycle result strobe.
REQ-012 SHALL have port result_o  output  32  quotient or remainder; meaningful only while valid_o=1, 0 otherwise.
REQ-013 SHALL have port rd_addr_o  output  5  latched rd_addr_i; meaningful while valid_o=1.
REQ-014 SHALL have port stallreq_o  output  1  stall request to the pipeline controller.

Function
REQ-015 SHALL implement an FSM with states IDLE, CALC, DONE.
REQ-016 In IDLE, start_i=1 and flush_i=0 SHALL latch op, rd_addr, operand signs, and operand magnitudes: two's-complement absolute values for DIV/REM, raw values for DIVU/REMU. It SHALL clear the 6-bit step counter and go to CALC.
REQ-017 CALC SHALL perform one restoring step per cycle: shift the {remainder, quotient} pair left by 1, trial-subtract the divisor magnitude, and set the quotient LSB to 1 and keep the difference when it is non-negative.
REQ-018 CALC SHALL take exactly 32 cycles; when the counter equals 31 the next state SHALL be DONE.
REQ-019 DONE SHALL last exactly one cycle with valid_o=1, then return to IDLE; start_i in CALC or DONE SHALL be ignored.
REQ-020 Latency: with start accepted at cycle T, valid_o SHALL be high in cycle T+33 only.
REQ-021 stallreq_o SHALL equal (IDLE and start_i and not flush_i) or CALC, combinationally; it SHALL be 0 in DONE.
REQ-022 Signed quotient SHALL be negated when the operand signs differ; signed remainder SHALL take the sign of the dividend.
REQ-023 Divisor zero SHALL yield quotient 0xFFFFFFFF with no sign correction, and remainder equal to dividend_i.
REQ-024 DIV/REM of 0x80000000 by 0xFFFFFFFF SHALL yield quotient 0x80000000 and remainder 0.
REQ-025 flush_i=1 in any state SHALL force IDLE on the next edge, and valid_o SHALL NOT assert for the aborted operation.
REQ-026 flush_i and start_i high together SHALL be treated as flush; the start is dropped.

Reset
REQ-027 rst=1 SHALL force IDLE, counter 0 and internal registers 0; busy_o, valid_o, result_o, rd_addr_o and stallreq_o SHALL read 0 from the next cycle.
REQ-028 Reset mid-CALC SHALL abort without producing valid_o.

Configuration
REQ-029 Macro DIV_ZERO_FAST_EN defined: divisor zero or the signed-overflow case SHALL go IDLE->DONE directly. valid_o SHALL assert at T+1 with the REQ-023/024 values, and stallreq_o SHALL be high only in cycle T.
REQ-030 Macro DIV_ZERO_FAST_EN undefined: those cases SHALL run the full 32-step CALC, with identical results and T+33 latency.

Verification
REQ-031 DIVU 100/7, rd=5 -> valid_o only at T+33, result_o=14, rd_addr_o=5, stallreq_o high T..T+32.
REQ-032 REM -7 (0xFFFFFFF9) / 2 -> result_o=0xFFFFFFFF; DIV of the same operands -> 0xFFFFFFFD.
REQ-033 DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5. T+1 with DIV_ZERO_FAST_EN defined, T+33 without.
REQ-034 DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
REQ-035 Flush at T+10 of a DIVU, then a new start at T+12 -> no valid_o for the first operation; second result at T+45.
REQ-036 rst at T+20 mid-CALC -> all outputs 0, state IDLE, no valid_o; start_i+flush_i in the same cycle -> request ignored.
